// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port arbiter in front of the shared EXE ALU, owner of SR {N,Z,C,V}
// One op in flight: IDLE accepts, EXEC samples the combinational ALU, RESP holds the result.
module alu_arbiter #(
  parameter bit         RR_EN  = 1'b1,
  parameter logic [3:0] SR_RST = 4'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_in1,
  input  logic [63:0] req_in2,
  input  logic [7:0]  req_cmd,
  input  logic [1:0]  req_s,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [31:0] resp_result,
  output logic [3:0]  resp_flags,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_cmd,
  output logic        alu_c_in,
  input  logic [31:0] alu_result,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_c,
  input  logic        alu_v,
  output logic [3:0]  sr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] in1_q, in1_d;
  logic [31:0] in2_q, in2_d;
  logic [3:0]  cmd_q, cmd_d;
  logic        s_q, s_d;
  logic        id_q, id_d;
  logic        last_served_q, last_served_d;
  logic [3:0]  sr_q, sr_d;
  logic [31:0] res_q, res_d;
  logic [3:0]  flg_q, flg_d;

  logic        grant_any;
  logic        grant_id;
  logic        is_arith;
  logic        is_logic;
  logic [3:0]  alu_flags;

  // Contention goes to the port not served last, or always to port 0 in fixed-priority mode.
  always_comb begin
    grant_any = |req_valid;
    grant_id  = req_valid[1];
    if (req_valid == 2'b11) begin
      grant_id = RR_EN ? ~last_served_q : 1'b0;
    end
  end

  always_comb begin
    is_arith  = (cmd_q >= 4'h2) && (cmd_q <= 4'h5);
    is_logic  = (cmd_q == 4'h1) || ((cmd_q >= 4'h6) && (cmd_q <= 4'h9));
    alu_flags = {alu_n, alu_z, alu_c, alu_v};
  end

  always_comb begin
    state_d       = state_q;
    in1_d         = in1_q;
    in2_d         = in2_q;
    cmd_d         = cmd_q;
    s_d           = s_q;
    id_d          = id_q;
    last_served_d = last_served_q;
    sr_d          = sr_q;
    res_d         = res_q;
    flg_d         = flg_q;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          in1_d   = grant_id ? req_in1[63:32] : req_in1[31:0];
          in2_d   = grant_id ? req_in2[63:32] : req_in2[31:0];
          cmd_d   = grant_id ? req_cmd[7:4]   : req_cmd[3:0];
          s_d     = grant_id ? req_s[1]       : req_s[0];
          id_d    = grant_id;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d = alu_result;
        flg_d = alu_flags;
        // Logic and move ops have no meaningful carry/overflow, so C and V survive them.
        if (s_q) begin
          if (is_arith) begin
            sr_d = alu_flags;
          end else if (is_logic) begin
            sr_d = {alu_n, alu_z, sr_q[1:0]};
          end
        end
        last_served_d = id_q;
        state_d       = S_RESP;
      end
      S_RESP: begin
        if (resp_ready[id_q]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      in1_q         <= 32'd0;
      in2_q         <= 32'd0;
      cmd_q         <= 4'd0;
      s_q           <= 1'b0;
      id_q          <= 1'b0;
      last_served_q <= 1'b1;
      sr_q          <= SR_RST;
      res_q         <= 32'd0;
      flg_q         <= 4'd0;
    end else begin
      state_q       <= state_d;
      in1_q         <= in1_d;
      in2_q         <= in2_d;
      cmd_q         <= cmd_d;
      s_q           <= s_d;
      id_q          <= id_d;
      last_served_q <= last_served_d;
      sr_q          <= sr_d;
      res_q         <= res_d;
      flg_q         <= flg_d;
    end
  end

  // Handshake and ALU outputs are gated by rst so nothing leaks while reset is held mid-op.
  always_comb begin
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    alu_in1    = 32'd0;
    alu_in2    = 32'd0;
    alu_cmd    = 4'd0;
    if (!rst) begin
      if ((state_q == S_IDLE) && grant_any) begin
        req_ready = grant_id ? 2'b10 : 2'b01;
      end
      if (state_q == S_RESP) begin
        resp_valid = id_q ? 2'b10 : 2'b01;
      end
      if (state_q == S_EXEC) begin
        alu_in1 = in1_q;
        alu_in2 = in2_q;
        alu_cmd = cmd_q;
      end
    end
  end

  assign alu_c_in    = sr_q[1];
  assign sr          = sr_q;
  assign resp_result = res_q;
  assign resp_flags  = flg_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a behavioural ALU
// A round-robin instance is scoreboarded; a fixed-priority instance shares its stimulus.
module tb_alu_arbiter;

  localparam logic [3:0] SR_RST = 4'h0;
  localparam logic [3:0] C_MOV = 4'h1, C_ADD = 4'h2, C_ADC = 4'h3, C_SUB = 4'h4,
                         C_SBC = 4'h5, C_AND = 4'h6, C_EOR = 4'h8, C_MVN = 4'h9;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [63:0] req_in1, req_in2;
  logic [7:0]  req_cmd;
  logic [1:0]  req_s;
  logic [1:0]  resp_ready;

  logic [1:0]  req_ready, resp_valid;
  logic [31:0] resp_result, alu_in1, alu_in2, alu_result;
  logic [3:0]  resp_flags, alu_cmd, sr;
  logic        alu_c_in, alu_n, alu_z, alu_c, alu_v;

  logic [1:0]  fp_req_ready, fp_resp_valid;
  logic [31:0] fp_resp_result, fp_alu_in1, fp_alu_in2, fp_alu_result;
  logic [3:0]  fp_resp_flags, fp_alu_cmd, fp_sr;
  logic        fp_alu_c_in, fp_alu_n, fp_alu_z, fp_alu_c, fp_alu_v;

  int tests_run = 0;
  int tests_failed = 0;

  function automatic logic [35:0] alu_f(input logic [3:0] cmd, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin);
    logic [32:0] w;
    logic [31:0] r;
    logic        c, v;
    w = 33'd0; r = 32'd0; c = 1'b0; v = 1'b0;
    case (cmd)
      C_MOV: r = b;
      C_MVN: r = ~b;
      C_ADD, C_ADC: begin
        w = {1'b0, a} + {1'b0, b} + {32'd0, (cmd == C_ADC) ? cin : 1'b0};
        r = w[31:0]; c = w[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      C_SUB, C_SBC: begin
        w = {1'b0, a} + {1'b0, ~b} + {32'd0, (cmd == C_SUB) ? 1'b1 : cin};
        r = w[31:0]; c = w[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      C_AND: r = a & b;
      4'h7:  r = a | b;
      C_EOR: r = a ^ b;
      default: r = 32'd0;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  function automatic logic [3:0] sr_next(input logic [3:0] cmd, input logic s,
                                         input logic [3:0] f, input logic [3:0] cur);
    if (!s) return cur;
    if (cmd >= 4'h2 && cmd <= 4'h5) return f;
    if (cmd == 4'h1 || (cmd >= 4'h6 && cmd <= 4'h9)) return {f[3:2], cur[1:0]};
    return cur;
  endfunction

  assign {alu_n, alu_z, alu_c, alu_v, alu_result} = alu_f(alu_cmd, alu_in1, alu_in2, alu_c_in);
  assign {fp_alu_n, fp_alu_z, fp_alu_c, fp_alu_v, fp_alu_result} =
      alu_f(fp_alu_cmd, fp_alu_in1, fp_alu_in2, fp_alu_c_in);

  alu_arbiter #(.RR_EN(1'b1), .SR_RST(SR_RST)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_cmd(req_cmd), .req_s(req_s),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_flags(resp_flags), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_cmd(alu_cmd),
    .alu_c_in(alu_c_in), .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z),
    .alu_c(alu_c), .alu_v(alu_v), .sr(sr)
  );

  alu_arbiter #(.RR_EN(1'b0), .SR_RST(SR_RST)) dut_fp (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(fp_req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_cmd(req_cmd), .req_s(req_s),
    .resp_valid(fp_resp_valid), .resp_ready(resp_ready), .resp_result(fp_resp_result),
    .resp_flags(fp_resp_flags), .alu_in1(fp_alu_in1), .alu_in2(fp_alu_in2),
    .alu_cmd(fp_alu_cmd), .alu_c_in(fp_alu_c_in), .alu_result(fp_alu_result),
    .alu_n(fp_alu_n), .alu_z(fp_alu_z), .alu_c(fp_alu_c), .alu_v(fp_alu_v), .sr(fp_sr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        p;
    logic [31:0] res;
    logic [3:0]  flg;
    logic [3:0]  sr_after;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_e;
  logic [35:0] m_o;
  logic [3:0]  sr_m = SR_RST;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      sr_m = SR_RST;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (resp_valid[p] && resp_ready[p]) begin
          tests_run++;
          if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL sb_unexpected_resp port=%0d result=%h", p, resp_result);
          end else begin
            m_e = sb.pop_front();
            if (m_e.p !== p[0] || resp_result !== m_e.res || resp_flags !== m_e.flg ||
                sr !== m_e.sr_after) begin
              tests_failed++;
              $display("FAIL sb_resp port=%0d/%0d result=%h/%h flags=%b/%b sr=%b/%b (got/exp)",
                       p, m_e.p, resp_result, m_e.res, resp_flags, m_e.flg, sr, m_e.sr_after);
            end
          end
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (req_valid[p] && req_ready[p]) begin
          m_o = alu_f(req_cmd[p*4 +: 4], req_in1[p*32 +: 32], req_in2[p*32 +: 32], sr_m[1]);
          m_e.p = p[0];
          m_e.res = m_o[31:0];
          m_e.flg = m_o[35:32];
          sr_m = sr_next(req_cmd[p*4 +: 4], req_s[p], m_o[35:32], sr_m);
          m_e.sr_after = sr_m;
          sb.push_back(m_e);
        end
      end
    end
  end

  task automatic set_req(input int p, input logic [3:0] cmd, input logic [31:0] a,
                         input logic [31:0] b, input logic s);
    req_in1[p*32 +: 32] = a;
    req_in2[p*32 +: 32] = b;
    req_cmd[p*4 +: 4]   = cmd;
    req_s[p]            = s;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 2'b00; resp_ready = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic do_op(input int p, input logic [3:0] cmd, input logic [31:0] a,
                       input logic [31:0] b, input logic s, output logic [31:0] res,
                       output logic [3:0] flg, output logic cin_obs);
    bit ok;
    res = 32'd0; flg = 4'd0; cin_obs = 1'b0;
    @(posedge clk); #1;
    set_req(p, cmd, a, b, s);
    req_valid[p] = 1'b1;
    resp_ready[p] = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[p]) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
    if (!ok) begin
      tests_run++; tests_failed++;
      $display("FAIL do_op_accept port=%0d never accepted", p);
      resp_ready[p] = 1'b0;
      return;
    end
    @(negedge clk);
    cin_obs = alu_c_in;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid[p]) begin ok = 1; break; end
    end
    if (!ok) begin
      tests_run++; tests_failed++;
      $display("FAIL do_op_resp port=%0d no response", p);
    end
    res = resp_result;
    flg = resp_flags;
    @(posedge clk); #1;
    resp_ready[p] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11; resp_ready = 2'b00;
    req_in1 = '0; req_in2 = '0; req_cmd = '0; req_s = '0;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (req_ready !== 2'b00 || resp_valid !== 2'b00 || alu_cmd !== 4'd0 || alu_in1 !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs req_ready=%b resp_valid=%b alu_cmd=%h alu_in1=%h want 0",
               req_ready, resp_valid, alu_cmd, alu_in1);
    end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 2'b00;
    @(negedge clk);
    tests_run++;
    if (sr !== SR_RST || resp_result !== 32'd0 || resp_flags !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_regs sr=%b result=%h flags=%b want %b/0/0", sr, resp_result,
               resp_flags, SR_RST);
    end
  endtask

  task automatic test_add_latency();
    bit ok;
    @(posedge clk); #1;
    set_req(0, C_ADD, 32'd7, 32'd5, 1'b1);
    req_valid[0] = 1'b1; resp_ready = 2'b00;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_ready[0]) begin ok = 1; break; end
    end
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL add_accept req_ready[0] never 1"); end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    tests_run++;
    if (resp_valid !== 2'b00 || alu_cmd !== C_ADD || alu_in1 !== 32'd7 || alu_in2 !== 32'd5) begin
      tests_failed++;
      $display("FAIL add_exec resp_valid=%b alu_cmd=%h in1=%h in2=%h want 00/2/7/5",
               resp_valid, alu_cmd, alu_in1, alu_in2);
    end
    @(negedge clk);
    tests_run++;
    if (resp_valid !== 2'b01 || resp_result !== 32'd12 || resp_flags !== 4'b0000 || sr !== 4'b0000) begin
      tests_failed++;
      $display("FAIL add_resp resp_valid=%b result=%h flags=%b sr=%b want 01/c/0000/0000",
               resp_valid, resp_result, resp_flags, sr);
    end
    @(posedge clk); #1;
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    resp_ready[0] = 1'b0;
    @(negedge clk);
    tests_run++;
    if (resp_valid !== 2'b00) begin
      tests_failed++;
      $display("FAIL add_consumed resp_valid=%b want 00", resp_valid);
    end
  endtask

  task automatic test_adc_chain();
    logic [31:0] r;
    logic [3:0]  f;
    logic        c;
    do_op(0, C_SUB, 32'd3, 32'd3, 1'b1, r, f, c);
    tests_run++;
    if (f !== 4'b0110 || sr !== 4'b0110) begin
      tests_failed++;
      $display("FAIL sub_zero flags=%b sr=%b want 0110/0110", f, sr);
    end
    do_op(0, C_ADC, 32'd1, 32'd1, 1'b1, r, f, c);
    tests_run++;
    if (c !== 1'b1 || r !== 32'd3) begin
      tests_failed++;
      $display("FAIL adc_chain c_in=%b result=%h want 1/3", c, r);
    end
    do_op(1, C_SBC, 32'd10, 32'd3, 1'b1, r, f, c);
    tests_run++;
    if (c !== 1'b0 || r !== 32'd6) begin
      tests_failed++;
      $display("FAIL sbc_chain c_in=%b result=%h want 0/6", c, r);
    end
  endtask

  task automatic test_flags_keep();
    logic [31:0] r;
    logic [3:0]  f;
    logic        c;
    do_op(0, C_ADD, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, r, f, c);
    tests_run++;
    if (sr !== 4'b0011) begin tests_failed++; $display("FAIL sr_setup sr=%b want 0011", sr); end
    do_op(1, C_AND, 32'h0000_00F0, 32'h0000_000F, 1'b1, r, f, c);
    tests_run++;
    if (r !== 32'd0 || sr !== 4'b0111) begin
      tests_failed++;
      $display("FAIL and_keep_cv result=%h sr=%b want 0/0111", r, sr);
    end
    do_op(0, 4'hA, 32'd5, 32'd6, 1'b1, r, f, c);
    tests_run++;
    if (sr !== 4'b0111) begin tests_failed++; $display("FAIL unlisted_cmd sr=%b want 0111", sr); end
  endtask

  task automatic test_hold();
    bit ok;
    @(posedge clk); #1;
    set_req(0, C_ADD, 32'd100, 32'd23, 1'b0);
    req_valid[0] = 1'b1; resp_ready = 2'b00;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_ready[0]) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    set_req(1, C_EOR, 32'h0000_00FF, 32'h0000_000F, 1'b1);
    req_valid[1] = 1'b1;
    resp_ready[1] = 1'b1;
    for (int i = 0; i < 10 && ok; i++) begin
      @(negedge clk);
      if (resp_valid[0]) break;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests_run++;
      if (resp_valid !== 2'b01 || resp_result !== 32'd123 || req_ready !== 2'b00) begin
        tests_failed++;
        $display("FAIL hold cyc=%0d resp_valid=%b result=%h req_ready=%b want 01/7b/00",
                 i, resp_valid, resp_result, req_ready);
      end
    end
    @(posedge clk); #1;
    resp_ready[0] = 1'b1;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_ready[1]) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    req_valid[1] = 1'b0; resp_ready[0] = 1'b0;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid[1]) begin ok = 1; break; end
    end
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL hold_port1 no response after wait"); end
    @(posedge clk); #1;
    resp_ready = 2'b00;
  endtask

  task automatic test_rr();
    int seq[4];
    int n = 0;
    int fp_cnt = 0;
    bit fp_bad = 0;
    pulse_reset();
    set_req(0, C_ADD, 32'd1, 32'd2, 1'b0);
    set_req(1, C_ADD, 32'd10, 32'd20, 1'b0);
    req_valid = 2'b11; resp_ready = 2'b11;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (fp_req_ready[1]) fp_bad = 1;
      if (fp_req_ready[0]) fp_cnt++;
      if (req_ready != 2'b00) begin
        seq[n] = req_ready[1] ? 1 : 0;
        n++;
      end
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (5) @(posedge clk);
    #1 resp_ready = 2'b00;
    tests_run++;
    if (n !== 4 || seq[0] !== 0 || seq[1] !== 1 || seq[2] !== 0 || seq[3] !== 1) begin
      tests_failed++;
      $display("FAIL rr_order n=%0d seq=%0d%0d%0d%0d want 4/0101", n, seq[0], seq[1], seq[2], seq[3]);
    end
    tests_run++;
    if (fp_bad || fp_cnt < 2) begin
      tests_failed++;
      $display("FAIL fixed_prio port1_granted=%0d port0_grants=%0d want 0/>=2", fp_bad, fp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic [3:0]  f;
    logic        c;
    bit          ok;
    do_op(0, C_MVN, 32'd0, 32'd0, 1'b1, r, f, c);
    @(posedge clk); #1;
    set_req(0, C_ADD, 32'd1, 32'd1, 1'b1);
    req_valid[0] = 1'b1; resp_ready = 2'b11;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_ready[0]) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 2'b00;
    @(negedge clk);
    tests_run++;
    if (!ok || resp_valid !== 2'b00 || alu_cmd !== 4'd0) begin
      tests_failed++;
      $display("FAIL rst_in_exec accepted=%0d resp_valid=%b alu_cmd=%h want 1/00/0",
               ok, resp_valid, alu_cmd);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    ok = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid !== 2'b00) ok = 0;
    end
    tests_run++;
    if (!ok || sr !== SR_RST) begin
      tests_failed++;
      $display("FAIL rst_dropped no_resp=%0d sr=%b want 1/%b", ok, sr, SR_RST);
    end
    @(posedge clk); #1;
    set_req(0, C_EOR, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1);
    set_req(1, C_ADD, 32'd9, 32'd9, 1'b1);
    req_valid = 2'b11;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 2'b01) begin
      tests_failed++;
      $display("FAIL rst_first_grant req_ready=%b want 01", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (4) @(posedge clk);
    #1 resp_ready = 2'b00;
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_adc_chain();
    test_flags_keep();
    test_hold();
    test_rr();
    test_reset_mid();
    @(negedge clk);
    tests_run++;
    if (sb.size() !== 0) begin
      tests_failed++;
      $display("FAIL sb_drain outstanding=%0d want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
